// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the round-robin UART transmit arbiter.
// Optional even parity is enabled by defining UART_TX_ARBITER_PARITY_EN.
package uart_tx_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_TX_ARBITER_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } tx_state_e;

    localparam int DATA_BITS = 8;
`ifdef UART_TX_ARBITER_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    function automatic int uart_divider(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_tx_core.sv
// Serialiser: baud counter, shift register, bit counter and line driver for 8N1 frames.
// UART_TX_ARBITER_PARITY_EN inserts an even-parity bit between DATA and STOP.
module uart_tx_core
    import uart_tx_arbiter_pkg::*;
#(
    parameter int DIVIDER = 10416
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    output logic       busy,
    output logic       tx
);

    localparam int CW = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;

    tx_state_e     state, state_next;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          bit_done;
`ifdef UART_TX_ARBITER_PARITY_EN
    logic          parity_bit;
`endif

    assign bit_done = (baud_cnt == CW'(DIVIDER - 1));
    assign busy     = (state != ST_IDLE);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        state_next = state;
        tx         = 1'b1;
        case (state)
            ST_IDLE: begin
                if (start) state_next = ST_START;
            end
            ST_START: begin
                tx = 1'b0;
                if (bit_done) state_next = ST_DATA;
            end
            ST_DATA: begin
                tx = shreg[0];
                if (bit_done && bit_cnt == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_ARBITER_PARITY_EN
                    state_next = ST_PARITY;
`else
                    state_next = ST_STOP;
`endif
                end
            end
`ifdef UART_TX_ARBITER_PARITY_EN
            ST_PARITY: begin
                tx = parity_bit;
                if (bit_done) state_next = ST_STOP;
            end
`endif
            ST_STOP: begin
                if (bit_done) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
`ifdef UART_TX_ARBITER_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            state <= state_next;
            // Counter idles at zero and restarts on each bit boundary.
            if (state == ST_IDLE || bit_done) baud_cnt <= '0;
            else                              baud_cnt <= baud_cnt + 1'b1;

            if (state == ST_IDLE) begin
                bit_cnt <= '0;
                if (start) begin
                    shreg <= data;
`ifdef UART_TX_ARBITER_PARITY_EN
                    parity_bit <= ^data;
`endif
                end
            end else if (state == ST_DATA && bit_done) begin
                bit_cnt <= bit_cnt + 1'b1;
                shreg   <= shreg >> 1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding one UART transmitter; grants only while the line is idle.
// Defining UART_TX_ARBITER_PARITY_EN builds the 11-bit even-parity frame.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD_RATE = 9600,
    parameter int N_REQ     = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [8*N_REQ-1:0]       req_data,
    output logic [N_REQ-1:0]         req_ready,
    output logic                     uart_tx,
    output logic                     busy,
    output logic [$clog2(N_REQ)-1:0] grant_id
);

    localparam int DIVIDER = uart_divider(CLK_FREQ, BAUD_RATE);
    localparam int GW      = $clog2(N_REQ);

    logic [7:0]    req_bytes [N_REQ];
    logic [GW-1:0] rr_ptr;
    logic [GW-1:0] cand;
    logic [GW-1:0] pick_idx;
    logic          pick_found;
    logic          start;

    always_comb begin
        for (int i = 0; i < N_REQ; i++) req_bytes[i] = req_data[8*i +: 8];
    end

    // Search starts one past the last grant and wraps modulo N_REQ.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand = GW'((int'(rr_ptr) + i) % N_REQ);
            if (!pick_found && req_valid[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    assign start = !busy && pick_found && !rst;

    always_comb begin
        req_ready = '0;
        if (start) req_ready[pick_idx] = 1'b1;
    end

    // rr_ptr resets to the last index so requester 0 wins first; grant_id reports 0 from reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr   <= GW'(N_REQ - 1);
            grant_id <= '0;
        end else if (start) begin
            rr_ptr   <= pick_idx;
            grant_id <= pick_idx;
        end
    end

    uart_tx_core #(
        .DIVIDER (DIVIDER)
    ) u_core (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .data  (req_bytes[pick_idx]),
        .busy  (busy),
        .tx    (uart_tx)
    );

endmodule
